if_id_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the ARMv8 core. It owns the PC, fetches 32-bit instructions over a req/ack instruction-memory handshake, and buffers them in a 2-entry queue (output register plus skid register). Its registered outputs carry the instruction's low 26 bits and a 3-bit immediate-class code that drive the downstream sign-extender directly. It supports downstream back-pressure and branch redirect with flush.

---
 rtl/if_id_stage_pkg.sv | 20 ++
 rtl/if_id_stage_imm_class_decode.sv | 13 +
 rtl/if_id_stage.sv | 93 +++++++++
 tb/tb_if_id_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared encodings for the fetch stage and its immediate-class decoder.
package if_id_stage_pkg;
   typedef enum logic [2:0] {
      SE_I    = 3'b000,
      SE_D    = 3'b001,
      SE_B    = 3'b010,
      SE_CB   = 3'b011,
      SE_MOVZ = 3'b100
   } se_t;

   typedef enum logic [1:0] {S_INIT, S_FETCH, S_DISCARD} state_t;

   localparam logic [5:0]  OP_B    = 6'b000101;
   localparam logic [5:0]  OP_BL   = 6'b100101;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ = 8'b10110101;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [8:0]  OP_MOVZ = 9'b110100101;
endpackage

// File: rtl/if_id_stage_imm_class_decode.sv
// imm_class_decode: maps an instruction's opcode field (instr[31:21]) to its immediate class.
module imm_class_decode
   import if_id_stage_pkg::*;
(
   input  logic [10:0] op,
   output se_t         cls
);
   always_comb
      cls = (op[10:5] == OP_B || op[10:5] == OP_BL)       ? SE_B    :
            (op[10:3] == OP_CBZ || op[10:3] == OP_CBNZ)   ? SE_CB   :
            (op == OP_LDUR || op == OP_STUR)              ? SE_D    :
            (op[10:2] == OP_MOVZ)                         ? SE_MOVZ : SE_I;
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC owner, req/ack instruction fetch and 2-entry IF/ID queue (output + skid)
// with back-pressure and branch redirect/flush.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int PC_STEP    = 4
)(
   input  logic                  CLK,
   input  logic                  Reset_L,
   input  logic [ADDR_WIDTH-1:0] StartPC,
   output logic                  IMemReq,
   output logic [ADDR_WIDTH-1:0] IMemAddr,
   input  logic                  IMemAck,
   input  logic [31:0]           IMemData,
   input  logic                  BranchTaken,
   input  logic [ADDR_WIDTH-1:0] BranchTarget,
   input  logic                  IdReady,
   output logic                  IdValid,
   output logic [31:0]           IdInstr,
   output logic [ADDR_WIDTH-1:0] IdPC,
   output logic [25:0]           Imm26,
   output logic [2:0]            SignExtCtrl
);
   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] pc, req_addr, skid_pc;
   logic [31:0]           skid_instr;
   logic                  pending, skid_valid, acc;
   se_t                   in_cls, skid_cls, out_cls;

   imm_class_decode u_dec (.op(IMemData[31:21]), .cls(in_cls));

   // An outstanding request keeps its original address even after PC is redirected.
   assign IMemAddr    = pending ? req_addr : pc;
   assign IMemReq     = (state == S_DISCARD) || (state == S_FETCH && (pending || !skid_valid));
   assign acc         = state == S_FETCH && IMemReq && IMemAck && !BranchTaken;
   assign Imm26       = IdInstr[25:0];
   assign SignExtCtrl = out_cls;

   always_ff @(posedge CLK or negedge Reset_L)
      if (!Reset_L) state <= S_INIT;
      else state <= state_nx;

   always_comb
      state_nx = (state == S_INIT)    ? S_FETCH :
                 (state == S_DISCARD) ? (IMemAck ? S_FETCH : S_DISCARD) :
                 (BranchTaken && IMemReq && !IMemAck) ? S_DISCARD : S_FETCH;

   always_ff @(posedge CLK or negedge Reset_L)
      if (!Reset_L) begin
         pc         <= '0;
         req_addr   <= '0;
         pending    <= 1'b0;
         IdValid    <= 1'b0;
         IdInstr    <= '0;
         IdPC       <= '0;
         out_cls    <= SE_I;
         skid_valid <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
         skid_cls   <= SE_I;
      end else begin
         pending  <= IMemReq && !IMemAck;
         req_addr <= IMemAddr;
         if (state == S_INIT) pc <= StartPC;
         else if (BranchTaken) pc <= BranchTarget;
         else if (acc) pc <= IMemAddr + ADDR_WIDTH'(PC_STEP);
         if (BranchTaken) begin
            IdValid    <= 1'b0;
            skid_valid <= 1'b0;
         end else if (IdValid && IdReady && skid_valid) begin
            IdInstr    <= skid_instr;
            IdPC       <= skid_pc;
            out_cls    <= skid_cls;
            skid_valid <= acc;
            if (acc) begin
               skid_instr <= IMemData;
               skid_pc    <= IMemAddr;
               skid_cls   <= in_cls;
            end
         end else if (acc && (!IdValid || IdReady)) begin
            IdValid <= 1'b1;
            IdInstr <= IMemData;
            IdPC    <= IMemAddr;
            out_cls <= in_cls;
         end else if (acc) begin
            skid_valid <= 1'b1;
            skid_instr <= IMemData;
            skid_pc    <= IMemAddr;
            skid_cls   <= in_cls;
         end else if (IdReady) IdValid <= 1'b0;
      end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed bench with a latency-programmable memory model and an in-order output scoreboard.
module tb_if_id_stage;
   logic        CLK = 0, Reset_L = 1;
   logic [63:0] StartPC, IMemAddr, BranchTarget, IdPC;
   logic        IMemReq, IMemAck, BranchTaken, IdReady, IdValid;
   logic [31:0] IMemData, IdInstr;
   logic [25:0] Imm26;
   logic [2:0]  SignExtCtrl;
   logic [31:0] prog [16];
   logic [63:0] sb [$];
   int          lat = 0, cnt = 0, total = 0, bad = 0;

   if_id_stage dut (
      .CLK(CLK), .Reset_L(Reset_L), .StartPC(StartPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
      .IMemAck(IMemAck), .IMemData(IMemData), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .IdReady(IdReady), .IdValid(IdValid), .IdInstr(IdInstr), .IdPC(IdPC), .Imm26(Imm26),
      .SignExtCtrl(SignExtCtrl)
   );

   always #5 CLK = ~CLK;

   assign IMemAck  = IMemReq && (cnt >= lat);
   assign IMemData = prog[IMemAddr[5:2]];

   always @(posedge CLK or negedge Reset_L)
      if (!Reset_L) cnt <= 0;
      else cnt <= (IMemReq && !IMemAck) ? cnt + 1 : 0;

   function automatic logic [2:0] exp_cls(input logic [31:0] w);
      casez (w[31:21])
         11'b000101?????, 11'b100101?????: return 3'b010;
         11'b1011010????:                  return 3'b011;
         11'b111110000?0:                  return 3'b001;
         11'b110100101??:                  return 3'b100;
         default:                          return 3'b000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic rst_check;
      chk("rst_req", IMemReq, 0);
      chk("rst_addr", IMemAddr, 0);
      chk("rst_valid", IdValid, 0);
      chk("rst_instr", IdInstr, 0);
      chk("rst_pc", IdPC, 0);
      chk("rst_imm", Imm26, 0);
      chk("rst_cls", SignExtCtrl, 0);
   endtask

   task automatic do_reset;
      Reset_L = 0;
      #1 rst_check();
      repeat (2) step();
      Reset_L = 1;
   endtask

   // Each accepted output must match the next expected PC and its instruction/class.
   always @(negedge CLK)
      if (Reset_L && IdValid && IdReady) begin
         if (sb.size() == 0) chk("sb_extra", IdPC, 64'hdead);
         else begin
            logic [63:0] p;
            logic [31:0] w;
            p = sb.pop_front();
            w = prog[p[5:2]];
            chk("sb_pc", IdPC, p);
            chk("sb_instr", IdInstr, w);
            chk("sb_imm", Imm26, w[25:0]);
            chk("sb_cls", SignExtCtrl, exp_cls(w));
         end
      end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) prog[i] = 32'h8B000000 | i;
      prog[0] = 32'h91001441; prog[1] = 32'hF8408041; prog[2] = 32'h14000003;
      prog[3] = 32'hB4000040; prog[4] = 32'hD2800020; prog[5] = 32'h94000010;
      prog[6] = 32'hB5000020; prog[7] = 32'hF8000041; prog[8] = 32'hD1000421;
      StartPC = 64'h1000; BranchTaken = 0; BranchTarget = 0; IdReady = 0;
      #2;
      // streaming, stall with skid fill, ordered drain
      do_reset();
      for (int a = 0; a < 8; a++) sb.push_back(64'h1000 + 4 * a);
      IdReady = 1;
      chk("init_req", IMemReq, 0);
      step();
      chk("f0_req", IMemReq, 1);
      chk("f0_addr", IMemAddr, 64'h1000);
      chk("f0_valid", IdValid, 0);
      step();
      chk("o0_valid", IdValid, 1);
      chk("o0_pc", IdPC, 64'h1000);
      chk("o0_imm", Imm26, 26'h1001441);
      chk("o0_cls", SignExtCtrl, 3'b000);
      chk("o0_next", IMemAddr, 64'h1004);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("str_pc", IdPC, 64'h1000 + 4 * k);
         chk("str_cls", SignExtCtrl, k);
      end
      IdReady = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_req", IMemReq, 0);
         chk("stall_pc", IdPC, 64'h1010);
      end
      IdReady = 1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("drain_pc", IdPC, 64'h1010 + 4 * k);
      end
      step();
      IdReady = 0;
      step();
      chk("sb_empty1", sb.size(), 0);
      // redirect with outstanding slow request, then redirect with same-cycle ack
      do_reset();
      sb.push_back(64'h1000); sb.push_back(64'h1004); sb.push_back(64'h2000);
      IdReady = 1;
      repeat (3) step();
      chk("b_pc", IdPC, 64'h1004);
      lat = 2; BranchTaken = 1; BranchTarget = 64'h2000;
      #1;
      chk("b_out_req", IMemReq, 1);
      chk("b_out_addr", IMemAddr, 64'h1008);
      chk("b_out_ack", IMemAck, 0);
      step();
      BranchTaken = 0;
      chk("d_valid", IdValid, 0);
      chk("d_req", IMemReq, 1);
      chk("d_addr", IMemAddr, 64'h1008);
      step();
      chk("d_ack", IMemAck, 1);
      chk("d_addr2", IMemAddr, 64'h1008);
      chk("d_valid2", IdValid, 0);
      step();
      chk("t_valid", IdValid, 0);
      chk("t_addr", IMemAddr, 64'h2000);
      chk("t_req", IMemReq, 1);
      lat = 0;
      step();
      chk("t_ovalid", IdValid, 1);
      chk("t_opc", IdPC, 64'h2000);
      BranchTaken = 1; BranchTarget = 64'h3000;
      #1 chk("sa_ack", IMemAck, 1);
      step();
      BranchTaken = 0;
      chk("sa_valid", IdValid, 0);
      chk("sa_req", IMemReq, 1);
      chk("sa_addr", IMemAddr, 64'h3000);
      step();
      chk("sa_ovalid", IdValid, 1);
      chk("sa_opc", IdPC, 64'h3000);
      IdReady = 0; lat = 5;
      step();
      chk("mr_req", IMemReq, 1);
      chk("mr_addr", IMemAddr, 64'h3004);
      chk("sb_empty2", sb.size(), 0);
      // asynchronous reset in the middle of a pending request
      Reset_L = 0;
      #1 rst_check();
      StartPC = 64'h4000; lat = 0;
      sb.push_back(64'h4000);
      repeat (2) step();
      IdReady = 1;
      Reset_L = 1;
      step();
      chk("rs_req", IMemReq, 1);
      chk("rs_addr", IMemAddr, 64'h4000);
      step();
      chk("rs_pc", IdPC, 64'h4000);
      step();
      chk("rs_pc2", IdPC, 64'h4004);
      IdReady = 0;
      step();
      chk("sb_empty3", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
